bmc_pipe: RTL and testbench

BMC_PIPE -- requirements
Module: bmc_pipe

---
 rtl/bmc_pipe.sv | 119 +++++++++++
 tb/tb_bmc_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_pipe.sv
// Branch-metric pipeline for a rate-1/N soft/hard-decision decoder.
// Two register stages: S1 holds per-bit distances for every expected pattern,
// S2 holds the summed metrics, the index of the smallest one and out_valid.
module bmc_pipe #(
    parameter int unsigned N  = 2,
    parameter int unsigned SW = 3,
    localparam int unsigned MW = SW + $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*SW-1:0]         rx_sym,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(2**N)*MW-1:0]    bm,
    output logic [N-1:0]            min_idx,
    output logic [15:0]             sym_cnt
);

    localparam int unsigned P = 2 ** N;
    localparam logic [SW-1:0] SMax = {SW{1'b1}};

    logic                         s1_valid_q, s1_valid_d;
    logic                         s2_valid_q, s2_valid_d;
    logic [P-1:0][N-1:0][SW-1:0]  s1_dist_q, s1_dist_d;
    logic [P*MW-1:0]              bm_q, bm_d;
    logic [N-1:0]                 min_idx_q, min_idx_d;
    logic [15:0]                  sym_cnt_q, sym_cnt_d;
    logic                         adv1, adv2, accept, out_xfer;
    logic [N-1:0][SW-1:0]         d_zero, d_one;
    logic [P-1:0][MW-1:0]         sum;

    // Handshake: a stage may advance when it is empty or its successor advances
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1 && !flush;
        accept   = in_valid && in_ready;
        out_xfer = s2_valid_q && out_ready && !flush;
    end

    // S1 next state: distance of each sample to '0' and '1', fanned out per pattern
    always_comb begin
        d_zero     = '0;
        d_one      = '0;
        s1_dist_d  = s1_dist_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (mode) begin
                d_zero[i] = rx_sym[i*SW +: SW];
                d_one[i]  = SMax - rx_sym[i*SW +: SW];
            end else begin
                d_zero[i] = SW'(rx_sym[i*SW+SW-1]);
                d_one[i]  = SW'(!rx_sym[i*SW+SW-1]);
            end
        end
        if (accept) begin
            for (int unsigned p = 0; p < P; p++) begin
                for (int unsigned i = 0; i < N; i++) begin
                    s1_dist_d[p][i] = (((p >> i) & 1) != 0) ? d_one[i] : d_zero[i];
                end
            end
        end
        s1_valid_d = flush ? 1'b0 : (adv1 ? accept : s1_valid_q);
    end

    // S2 next state: metric sums, lowest-index minimum search, transfer counter
    always_comb begin
        for (int unsigned p = 0; p < P; p++) begin
            sum[p] = '0;
            for (int unsigned i = 0; i < N; i++) begin
                sum[p] = sum[p] + MW'(s1_dist_q[p][i]);
            end
        end
        bm_d      = bm_q;
        min_idx_d = min_idx_q;
        if (s1_valid_q && adv2 && !flush) begin
            min_idx_d = '0;
            for (int unsigned p = 0; p < P; p++) begin
                bm_d[p*MW +: MW] = sum[p];
            end
            // Strict compare keeps the lower index on ties
            for (int unsigned p = 1; p < P; p++) begin
                if (sum[p] < sum[min_idx_d]) begin
                    min_idx_d = N'(p);
                end
            end
        end
        s2_valid_d = flush ? 1'b0 : (adv2 ? s1_valid_q : s2_valid_q);
        sym_cnt_d  = out_xfer ? sym_cnt_q + 16'd1 : sym_cnt_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_dist_q  <= '0;
            bm_q       <= '0;
            min_idx_q  <= '0;
            sym_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_dist_q  <= s1_dist_d;
            bm_q       <= bm_d;
            min_idx_q  <= min_idx_d;
            sym_cnt_q  <= sym_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign bm        = bm_q;
    assign min_idx   = min_idx_q;
    assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_bmc_pipe.sv
// Self-checking bench for bmc_pipe (N=2, SW=3): constant vectors, hand-written
// corner sequences and a randomized run against a behavioural scoreboard.
module tb_bmc_pipe;

    localparam int N  = 2;
    localparam int SW = 3;
    localparam int MW = SW + $clog2(N);
    localparam int P  = 1 << N;

    logic               clk = 1'b0;
    logic               rst_n, flush, mode, in_valid, in_ready;
    logic               out_valid, out_ready;
    logic [N*SW-1:0]    rx_sym;
    logic [P*MW-1:0]    bm;
    logic [N-1:0]       min_idx;
    logic [15:0]        sym_cnt;

    always #5 clk = ~clk;

    bmc_pipe #(.N(N), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rx_sym    (rx_sym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bm        (bm),
        .min_idx   (min_idx),
        .sym_cnt   (sym_cnt)
    );

    typedef struct packed {
        logic [P*MW-1:0] bm;
        logic [N-1:0]    idx;
    } res_t;

    typedef struct {
        logic            m;
        logic [SW-1:0]   s0;
        logic [SW-1:0]   s1;
        logic [P*MW-1:0] bm;
        logic [N-1:0]    idx;
    } vec_t;

    res_t        sb_q[$];
    res_t        held;
    vec_t        vt[7];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_cnt;
    logic        last_acc, last_out, last_inrdy, prev_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: sum of per-bit distances straight from the metric definition
    function automatic res_t ref_res(input logic m, input logic [N*SW-1:0] rx);
        res_t r;
        int   sums[P];
        int   best;
        for (int p = 0; p < P; p++) begin
            sums[p] = 0;
            for (int i = 0; i < N; i++) begin
                int s;
                int e;
                s = int'(rx[i*SW +: SW]);
                e = (p >> i) & 1;
                if (m) sums[p] += (e == 1) ? ((1 << SW) - 1 - s) : s;
                else   sums[p] += ((s >= (1 << (SW - 1))) ? 1 : 0) ^ e;
            end
        end
        best = 0;
        for (int p = 1; p < P; p++) if (sums[p] < sums[best]) best = p;
        r.bm = '0;
        for (int p = 0; p < P; p++) r.bm[p*MW +: MW] = sums[p][MW-1:0];
        r.idx = best[N-1:0];
        return r;
    endfunction

    // One clock: observe handshakes mid-cycle, update scoreboard, advance to edge+1
    task automatic step();
        #4;
        if (flush) chk("flush_in_ready", in_ready, 0);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_bm", bm, held.bm);
            chk("stall_idx", min_idx, held.idx);
        end
        chk("sym_cnt", sym_cnt, exp_cnt);
        last_inrdy = in_ready;
        last_acc   = in_valid && in_ready && !flush;
        last_out   = out_valid && out_ready && !flush;
        if (last_out) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_out", 1, 0);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                chk("sb_bm", bm, e.bm);
                chk("sb_idx", min_idx, e.idx);
            end
            exp_cnt++;
        end
        prev_stall = out_valid && !out_ready && !flush;
        held.bm    = bm;
        held.idx   = min_idx;
        if (last_acc) sb_q.push_back(ref_res(mode, rx_sym));
        if (flush) sb_q.delete();
        chk("in_flight", sb_q.size() <= 2, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && (out_valid || sb_q.size() != 0); k++) step();
        chk("drain_empty", {out_valid, sb_q.size() == 0}, 2'b01);
    endtask

    task automatic run_vec(input int v);
        mode      = vt[v].m;
        rx_sym    = {vt[v].s1, vt[v].s0};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("tbl_acc", last_acc, 1);
        in_valid = 1'b0;
        chk("tbl_lat1", out_valid, 0);
        step();
        chk("tbl_valid", out_valid, 1);
        chk("tbl_bm", bm, vt[v].bm);
        chk("tbl_idx", min_idx, vt[v].idx);
        step();
        chk("tbl_done", out_valid, 0);
    endtask

    initial begin
        logic [15:0] cnt0;
        int          idx, got, stall;
        logic        first_seen, saw_block;
        logic [N*SW-1:0] bp_syms[4];

        // {mode, s0, s1, bm(p3..p0), min_idx}
        vt[0] = '{1'b1, 3'd7, 3'd0, 16'h7E07, 2'd1};
        vt[1] = '{1'b0, 3'd4, 3'd3, 16'h1201, 2'd1};
        vt[2] = '{1'b0, 3'd0, 3'd0, 16'h2110, 2'd0};
        vt[3] = '{1'b1, 3'd5, 3'd2, 16'h7A47, 2'd1};
        vt[4] = '{1'b0, 3'd5, 3'd2, 16'h1201, 2'd1};
        vt[5] = '{1'b1, 3'd0, 3'd7, 16'h70E7, 2'd2};
        vt[6] = '{1'b1, 3'd7, 3'd7, 16'h077E, 2'd3};

        rst_n = 1'b0; flush = 1'b0; mode = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; rx_sym = '0; exp_cnt = '0; prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bm", bm, 0);
        chk("rst_min_idx", min_idx, 0);
        chk("rst_sym_cnt", sym_cnt, 0);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);

        // Constant vectors, one symbol at a time
        for (int v = 0; v < 7; v++) begin
            run_vec(v);
            chk("tbl_cnt", sym_cnt, 16'(v + 1));
        end

        // Mode alternation on identical back-to-back symbols
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 4);
            mode     = (c % 2 == 0);
            rx_sym   = {3'd2, 3'd5};
            step();
            if (c >= 1 && c <= 4) begin
                chk("alt_valid", out_valid, 1);
                chk("alt_bm", bm, ((c - 1) % 2 == 0) ? 16'h7A47 : 16'h1201);
            end
        end
        drain();

        // Backpressure: 4 symbols, 3-cycle stall after the first result
        bp_syms[0] = {3'd1, 3'd6}; bp_syms[1] = {3'd3, 3'd3};
        bp_syms[2] = {3'd7, 3'd2}; bp_syms[3] = {3'd0, 3'd4};
        cnt0 = sym_cnt; idx = 0; got = 0; stall = 0;
        first_seen = 1'b0; saw_block = 1'b0; mode = 1'b1;
        for (int c = 0; c < 30 && got < 4; c++) begin
            in_valid = (idx < 4);
            rx_sym   = bp_syms[idx % 4];
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            step();
            if (in_valid && !last_inrdy) saw_block = 1'b1;
            if (last_acc) idx++;
            if (last_out) got++;
        end
        chk("bp_got", got, 4);
        chk("bp_in_ready_drop", saw_block, 1);
        chk("bp_cnt", sym_cnt, cnt0 + 16'd4);
        drain();

        // Flush with two symbols in flight and simultaneous transfers offered
        out_ready = 1'b0; in_valid = 1'b1; mode = 1'b1;
        rx_sym = {3'd6, 3'd1};
        step();
        chk("fl_acc0", last_acc, 1);
        rx_sym = {3'd2, 3'd2};
        step();
        chk("fl_acc1", last_acc, 1);
        cnt0 = sym_cnt;
        out_ready = 1'b1; flush = 1'b1;
        chk("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("fl_no_out", out_valid, 0);
        end
        chk("fl_cnt", sym_cnt, cnt0);

        // Randomized traffic with occasional flush
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 1'($urandom_range(0, 1));
            rx_sym    = (N*SW)'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        // Asynchronous reset mid-stream
        in_valid = 1'b1; out_ready = 1'b1; mode = 1'b1; rx_sym = {3'd0, 3'd7};
        step();
        step();
        chk("mrst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_bm", bm, 0);
        chk("mrst_min_idx", min_idx, 0);
        chk("mrst_sym_cnt", sym_cnt, 0);
        sb_q.delete(); exp_cnt = '0; prev_stall = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_in_ready", in_ready, 1);
        run_vec(0);
        chk("mrst_first_cnt", sym_cnt, 16'd1);

        // Counter wrap via streamed transfers
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 70000 && exp_cnt != 16'hFFFF; c++) begin
            mode   = 1'($urandom_range(0, 1));
            rx_sym = (N*SW)'($urandom);
            step();
        end
        chk("wrap_pre", sym_cnt, 16'hFFFF);
        in_valid = 1'b0;
        step();
        chk("wrap_xfer", last_out, 1);
        chk("wrap_cnt", sym_cnt, 16'h0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
